// File: rtl/alu_sequencer.sv
// Register-file sequencer that feeds an external combinational ALU and retires its result.
// Define ALU_SEQ_CAS_EN to turn opcode 3'b111 into a compare-and-swap; otherwise it is an ordinary op.
module alu_sequencer #(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 8,
    localparam int AW        = $clog2(REG_COUNT),
    localparam int CW        = 3 + 3*AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     command,
    input  logic              run,
    output logic              ready,
    output logic              done,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] y,
    input  logic              O,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    output logic [3:0]        flags,
    output logic              cas_ok
);

`ifdef ALU_SEQ_CAS_EN
    typedef enum logic [1:0] {IDLE, EXEC, CAS_CMP, CAS_WR} state_t;
`else
    typedef enum logic {IDLE, EXEC} state_t;
`endif

    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_a1, cmd_a2, cmd_a3;
    assign {cmd_op, cmd_a1, cmd_a2, cmd_a3} = command;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];
    logic [DATA_W-1:0]   regs_d [REG_COUNT];
    logic [AW-1:0]       a3_q, a3_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic [2:0]          op_q, op_d;
    logic [3:0]          flags_q, flags_d;
    logic                done_q, done_d, ready_q, ready_d;
`ifdef ALU_SEQ_CAS_EN
    logic [AW-1:0]       a1_q, a1_d, a2_q, a2_d;
    logic                hit_q, hit_d, cas_ok_q, cas_ok_d;
`endif

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        a3_d     = a3_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        op_d     = op_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_CAS_EN
        a1_d     = a1_q;
        a2_d     = a2_q;
        hit_d    = hit_q;
        cas_ok_d = cas_ok_q;
`endif
        case (state_q)
            IDLE: begin
                // A host load takes priority; a run in the same cycle is dropped.
                if (ld_en) begin
                    regs_d[ld_addr] = ld_data;
                end else if (run) begin
                    a3_d     = cmd_a3;
                    data_a_d = regs_q[cmd_a1];
                    data_b_d = regs_q[cmd_a2];
                    op_d     = cmd_op;
                    state_d  = EXEC;
`ifdef ALU_SEQ_CAS_EN
                    a1_d = cmd_a1;
                    a2_d = cmd_a2;
                    if (cmd_op == 3'b111) begin
                        op_d     = 3'b001;
                        data_b_d = regs_q[cmd_a3];
                        state_d  = CAS_CMP;
                    end
`endif
                end
            end
            EXEC: begin
                regs_d[a3_q] = y;
                flags_d      = {O, C, Z, N};
                done_d       = 1'b1;
                state_d      = IDLE;
            end
`ifdef ALU_SEQ_CAS_EN
            CAS_CMP: begin
                hit_d   = Z;
                flags_d = {O, C, Z, N};
                state_d = CAS_WR;
            end
            CAS_WR: begin
                // Status goes first so a swap into the status register overrides it.
                regs_d[REG_COUNT-1] = {{(DATA_W-1){1'b0}}, hit_q};
                if (hit_q)
                    regs_d[a1_q] = regs_q[a2_q];
                cas_ok_d = hit_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
            a3_q     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            op_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef ALU_SEQ_CAS_EN
            a1_q     <= '0;
            a2_q     <= '0;
            hit_q    <= 1'b0;
            cas_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            a3_q     <= a3_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            op_q     <= op_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef ALU_SEQ_CAS_EN
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            hit_q    <= hit_d;
            cas_ok_q <= cas_ok_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign rd_data     = regs_q[rd_addr];
    assign alu_op_code = op_q;
    assign data_a      = data_a_q;
    assign data_b      = data_b_q;
    assign flags       = flags_q;
`ifdef ALU_SEQ_CAS_EN
    assign cas_ok      = cas_ok_q;
`else
    assign cas_ok      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expectations, a monitor checks them
// on operand acceptance, on each done pulse, and for queued register reads.
module tb_alu_sequencer;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = 12;

    logic          clk, rst, run, ready, done, ld_en, cas_ok;
    logic [CW-1:0] command;
    logic [AW-1:0] ld_addr, rd_addr;
    logic [DW-1:0] ld_data, rd_data, data_a, data_b, y;
    logic [2:0]    alu_op_code;
    logic          O, C, Z, N;
    logic [3:0]    flags;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_exp = 0;

    typedef struct { logic [3:0] flags; logic cas_ok; int n; int a0; logic [31:0] v0; int a1; logic [31:0] v1; } dexp_t;
    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } oexp_t;
    typedef struct { int addr; logic [31:0] val; } rexp_t;
    dexp_t dq[$];
    oexp_t oq[$];
    rexp_t rq[$];

    alu_sequencer dut (
        .clk(clk), .rst(rst), .command(command), .run(run), .ready(ready), .done(done),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b), .y(y),
        .O(O), .C(C), .Z(Z), .N(N), .flags(flags), .cas_ok(cas_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU: 000 add, 001 subtract (C = borrow), anything else bitwise AND.
    always_comb begin
        y = '0;
        O = 1'b0;
        C = 1'b0;
        case (alu_op_code)
            3'b000: begin
                {C, y} = {1'b0, data_a} + {1'b0, data_b};
                O = (data_a[31] == data_b[31]) && (y[31] != data_a[31]);
            end
            3'b001: begin
                y = data_a - data_b;
                C = data_a < data_b;
                O = (data_a[31] != data_b[31]) && (y[31] != data_a[31]);
            end
            default: y = data_a & data_b;
        endcase
        Z = (y == '0);
        N = y[31];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input logic [2:0] op, input int a1, input int a2, input int a3);
        return {op, 3'(a1), 3'(a2), 3'(a3)};
    endfunction

    task automatic exp_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        oexp_t o;
        o.op = op; o.a = a; o.b = b;
        oq.push_back(o);
    endtask

    task automatic exp_done(input logic [3:0] f, input logic ok, input int n,
                            input int a0, input logic [31:0] v0, input int a1, input logic [31:0] v1);
        dexp_t d;
        d.flags = f; d.cas_ok = ok; d.n = n; d.a0 = a0; d.v0 = v0; d.a1 = a1; d.v1 = v1;
        dq.push_back(d);
        done_exp++;
    endtask

    task automatic exp_reg(input int a, input logic [31:0] v);
        rexp_t r;
        r.addr = a; r.val = v;
        rq.push_back(r);
    endtask

    task automatic load(input int a, input logic [31:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'(a); ld_data = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [CW-1:0] c);
        @(negedge clk);
        command = c; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((dq.size() + oq.size() + rq.size()) != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("queues_empty", 32'(dq.size() + oq.size() + rq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_data_a"}, data_a, 32'd0);
        chk({tag, "_data_b"}, data_b, 32'd0);
        chk({tag, "_op"}, 32'(alu_op_code), 32'd0);
        chk({tag, "_flags"}, 32'(flags), 32'd0);
        chk({tag, "_cas_ok"}, 32'(cas_ok), 32'd0);
    endtask

    // Monitor: acceptance (ready falls), retire (done), and queued register reads.
    initial begin
        logic  rdy_prev;
        dexp_t d;
        oexp_t o;
        rexp_t r;
        rdy_prev = 1'b1;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (rdy_prev && ready === 1'b0) begin
                if (oq.size() == 0) chk("unexpected_accept", 32'd1, 32'd0);
                else begin
                    o = oq.pop_front();
                    chk("accept_op", 32'(alu_op_code), 32'(o.op));
                    chk("accept_data_a", data_a, o.a);
                    chk("accept_data_b", data_b, o.b);
                end
            end
            rdy_prev = ready;
            if (done === 1'b1) begin
                done_cnt++;
                if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    d = dq.pop_front();
                    chk("done_flags", 32'(flags), 32'(d.flags));
                    chk("done_cas_ok", 32'(cas_ok), 32'(d.cas_ok));
                    if (d.n > 0) begin
                        rd_addr = 3'(d.a0);
                        #1 chk($sformatf("done_R%0d", d.a0), rd_data, d.v0);
                    end
                    if (d.n > 1) begin
                        rd_addr = 3'(d.a1);
                        #1 chk($sformatf("done_R%0d", d.a1), rd_data, d.v1);
                    end
                end
            end else if (rq.size() != 0) begin
                r = rq.pop_front();
                rd_addr = 3'(r.addr);
                #1 chk($sformatf("reg_R%0d", r.addr), rd_data, r.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; ld_en = 1'b0; command = '0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 8; i++) exp_reg(i, 32'd0);
        drain();

        // Basic add: R4 = R1 + R2
        load(1, 32'd5); load(2, 32'd3);
        exp_op(3'b000, 32'd5, 32'd3);
        exp_done(4'b0000, 1'b0, 1, 4, 32'd8, 0, 32'd0);
        issue(mk(3'b000, 1, 2, 4));
        drain();

`ifdef ALU_SEQ_CAS_EN
        // CAS miss then hit: compare R1 against R3, swap in R2
        load(1, 32'd7); load(2, 32'd9); load(3, 32'd6);
        exp_op(3'b001, 32'd7, 32'd6);
        exp_done(4'b0000, 1'b0, 2, 1, 32'd7, 7, 32'd0);
        issue(mk(3'b111, 1, 2, 3));
        drain();
        load(3, 32'd7);
        exp_op(3'b001, 32'd7, 32'd7);
        exp_done(4'b0010, 1'b1, 2, 1, 32'd9, 7, 32'd1);
        issue(mk(3'b111, 1, 2, 3));
        drain();
`else
        // Opcode 111 is an ordinary op: R3 = R1 & R2
        load(1, 32'd7); load(2, 32'd9); load(3, 32'd6);
        exp_op(3'b111, 32'd7, 32'd9);
        exp_done(4'b0000, 1'b0, 1, 3, 32'd1, 0, 32'd0);
        issue(mk(3'b111, 1, 2, 3));
        drain();
`endif

        // Destination equals source: R1 = R1 + R2
        load(1, 32'd10); load(2, 32'd4);
        exp_op(3'b000, 32'd10, 32'd4);
        exp_done(4'b0000, 1'b0, 1, 1, 32'd14, 0, 32'd0);
        issue(mk(3'b000, 1, 2, 1));
        drain();

        // run held high across EXEC with a new command: second op only after ready returns
        load(1, 32'd10);
        exp_op(3'b000, 32'd10, 32'd4);
        exp_op(3'b001, 32'd4, 32'd10);
        exp_done(4'b0000, 1'b0, 1, 5, 32'd14, 0, 32'd0);
        exp_done(4'b0101, 1'b0, 1, 6, 32'hFFFF_FFFA, 0, 32'd0);
        @(negedge clk);
        command = mk(3'b000, 1, 2, 5); run = 1'b1;
        @(negedge clk);
        command = mk(3'b001, 2, 1, 6);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        drain();

        // Load and run on the same edge: load wins, nothing starts
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'h0000_00A5;
        command = mk(3'b000, 1, 1, 0); run = 1'b1;
        @(negedge clk);
        ld_en = 1'b0; run = 1'b0;
        chk("ld_run_ready", 32'(ready), 32'd1);
        exp_reg(2, 32'h0000_00A5);
        exp_reg(0, 32'd0);
        drain();

        // Reset in the middle of an operation
        load(1, 32'd7); load(2, 32'd9); load(3, 32'd7); load(7, 32'h33);
`ifdef ALU_SEQ_CAS_EN
        exp_op(3'b001, 32'd7, 32'd7);
        issue(mk(3'b111, 1, 2, 3));
`else
        exp_op(3'b000, 32'd7, 32'd9);
        issue(mk(3'b000, 1, 2, 3));
`endif
        #2 rst = 1'b1;
        #1 chk_idle_outputs("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_release_ready", 32'(ready), 32'd1);
        exp_reg(1, 32'd0);
        exp_reg(3, 32'd0);
        exp_reg(7, 32'd0);
        drain();

        // Normal operation resumes after reset
        load(1, 32'd1); load(2, 32'd2);
        exp_op(3'b000, 32'd1, 32'd2);
        exp_done(4'b0000, 1'b0, 1, 0, 32'd3, 0, 32'd0);
        issue(mk(3'b000, 1, 2, 0));
        drain();

        chk("done_count", 32'(done_cnt), 32'(done_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
